// File: rtl/alu_seq_exec.sv
// EX-stage ALU: logic/add/sub/compare finish in 1 cycle; shifts take ceil(amt/SHIFT_STEP) extra cycles.
// Accepts only in IDLE (o_ready); the result is held in DONE until i_ready.
module alu_seq_exec #(
  parameter int XLEN       = 32,
  parameter int SHIFT_STEP = 1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_flush,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [2:0]      i_alu_ctl,
  input  logic [1:0]      i_alu_shift,
  input  logic [XLEN-1:0] i_op_a,
  input  logic [XLEN-1:0] i_op_b,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_result,
  output logic            o_zero,
  output logic            o_busy
);

  localparam logic [2:0] ALU_CTL_AND      = 3'd0;
  localparam logic [2:0] ALU_CTL_OR       = 3'd1;
  localparam logic [2:0] ALU_CTL_ADD      = 3'd2;
  localparam logic [2:0] ALU_CTL_XOR      = 3'd3;
  localparam logic [2:0] ALU_CTL_SHIFT    = 3'd4;
  localparam logic [2:0] ALU_CTL_LESS_UNS = 3'd5;
  localparam logic [2:0] ALU_CTL_SUB      = 3'd6;
  localparam logic [2:0] ALU_CTL_LESS_SIG = 3'd7;

  localparam logic [1:0] ALU_SHIFT_SLL = 2'd0;
  localparam logic [1:0] ALU_SHIFT_SRL = 2'd1;
  localparam logic [1:0] ALU_SHIFT_SRA = 2'd2;

  localparam logic [4:0] STEP5 = 5'(SHIFT_STEP);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [XLEN-1:0]   work;
  logic [XLEN-1:0]   step_val;
  logic [XLEN-1:0]   alu_res;
  logic [XLEN-1:0]   result;
  logic [4:0]        cnt;
  logic [4:0]        cnt_step;
  logic [1:0]        sh_type;
  logic [4:0]        amt;
  logic              shift_now;
  logic              last_step;

  assign amt       = i_op_b[4:0];
  assign shift_now = (i_alu_ctl == ALU_CTL_SHIFT) && (amt != 5'd0) &&
                     ((i_alu_shift == ALU_SHIFT_SLL) || (i_alu_shift == ALU_SHIFT_SRL) ||
                      (i_alu_shift == ALU_SHIFT_SRA));
  assign last_step = (cnt <= STEP5);
  assign cnt_step  = last_step ? 5'd0 : (cnt - STEP5);

  // Single-cycle ops; a shift that needs no iteration passes operand A through.
  always_comb begin
    alu_res = i_op_a;
    case (i_alu_ctl)
      ALU_CTL_AND:      alu_res = i_op_a & i_op_b;
      ALU_CTL_OR:       alu_res = i_op_a | i_op_b;
      ALU_CTL_XOR:      alu_res = i_op_a ^ i_op_b;
      ALU_CTL_ADD:      alu_res = i_op_a + i_op_b;
      ALU_CTL_SUB:      alu_res = i_op_a - i_op_b;
      ALU_CTL_LESS_SIG: alu_res = {{(XLEN-1){1'b0}}, ($signed(i_op_a) < $signed(i_op_b))};
      ALU_CTL_LESS_UNS: alu_res = {{(XLEN-1){1'b0}}, (i_op_a < i_op_b)};
      default:          alu_res = i_op_a;
    endcase
  end

  // Chain of SHIFT_STEP one-bit stages, each enabled only while bits remain.
  always_comb begin
    step_val = work;
    for (int i = 0; i < SHIFT_STEP; i++) begin
      if (5'(i) < cnt) begin
        case (sh_type)
          ALU_SHIFT_SLL: step_val = {step_val[XLEN-2:0], 1'b0};
          ALU_SHIFT_SRL: step_val = {1'b0, step_val[XLEN-1:1]};
          default:       step_val = {step_val[XLEN-1], step_val[XLEN-1:1]};
        endcase
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (i_flush) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (i_valid) state_nxt = shift_now ? S_SHIFT : S_DONE;
        S_SHIFT: if (last_step) state_nxt = S_DONE;
        S_DONE:  if (i_ready) state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    o_ready = (state == S_IDLE);
    o_valid = (state == S_DONE);
    o_busy  = (state != S_IDLE);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      work    <= '0;
      cnt     <= 5'd0;
      sh_type <= ALU_SHIFT_SLL;
      result  <= '0;
    end else if (i_flush) begin
      cnt <= 5'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_valid) begin
            if (shift_now) begin
              work    <= i_op_a;
              cnt     <= amt;
              sh_type <= i_alu_shift;
            end else begin
              result <= alu_res;
            end
          end
        end
        S_SHIFT: begin
          work <= step_val;
          cnt  <= cnt_step;
          if (last_step) result <= step_val;
        end
        default: ;
      endcase
    end
  end

  assign o_result = result;
  assign o_zero   = (result == '0);

endmodule
